exi_dump: RTL and testbench
===========================

EXI_DUMP -- requirements
Module: exi_dump

Interface
REQ-001 Parameter CLK_DIV, default 104: clk cycles per UART bit, legal range 4..65535.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every dump frame.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  one-cycle strobe: a captured EXI byte is valid.
REQ-006 wr_addr  input  8  buffer address of the captured byte; increments by 1 per byte and wraps 255->0.
REQ-007 wr_data  input  8  captured MOSI byte.
REQ-008 msg_end  input  1  one-cycle pulse when EXI chip-select deasserts (end of message).
REQ-009 uart_tx  output  1  8N1 serial dump output, idle high.
REQ-010 busy  output  1  high while a dump frame is being transmitted.
REQ-011 overflow  output  1  sticky error flag: capture data lost or truncated.

Function
REQ-012 The block SHALL hold a 256x8 capture RAM; wr_en while not busy writes wr_data to wr_addr.
REQ-013 The first accepted write after IDLE or after a completed dump SHALL latch wr_addr as msg_start and set count to 1; each later accepted write SHALL increment count.
REQ-014 count SHALL saturate at 255; a write at count==255 SHALL still update RAM, leave count at 255, and set overflow.
REQ-015 A wr_en asserted while busy SHALL be dropped (RAM unchanged) and SHALL set overflow.
REQ-016 FSM states: IDLE, SYNC, LEN, DATA, STOP_WAIT; reset state IDLE.
REQ-017 IDLE->SYNC on msg_end with count>0; msg_end with count==0 SHALL be ignored.
REQ-018 msg_end in the same cycle as an accepted wr_en SHALL include that byte in count.
REQ-019 msg_end while busy SHALL be ignored and SHALL NOT set overflow.
REQ-020 SYNC transmits SYNC_BYTE, LEN transmits count, DATA transmits RAM[(msg_start+i) mod 256] for i=0..count-1, in that order.
REQ-021 Frame length SHALL be count+2 bytes; consecutive bytes SHALL be back-to-back with no idle bit between stop and next start.
REQ-022 Each byte SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit exactly CLK_DIV cycles.
REQ-023 The start bit of SYNC SHALL begin on uart_tx no later than 2 cycles after the msg_end edge.
REQ-024 STOP_WAIT ends after the final stop bit's CLK_DIV cycles; FSM then returns to IDLE, clears count, deasserts busy.
REQ-025 busy SHALL be high from the cycle after msg_end acceptance through the last stop-bit cycle inclusive.
REQ-026 Address arithmetic for DATA reads SHALL be 8-bit modulo (wrap 255->0).
REQ-027 overflow SHALL be cleared only by rst.

Reset
REQ-028 On rst assertion, immediately and asynchronously: FSM=IDLE, uart_tx=1, busy=0, overflow=0, count=0, msg_start=0, bit/baud counters=0.
REQ-029 rst asserted mid-frame SHALL abort transmission with uart_tx forced high; RAM contents are undefined after reset.
REQ-030 After rst deasserts, the block SHALL accept writes on the first following clk edge.

Verification
REQ-031 CLK_DIV=4; writes 0x11,0x22,0x33 at addr 0,1,2; msg_end -> uart_tx frame A5,03,11,22,33, each byte 40 cycles, busy high exactly 200 cycles.
REQ-032 Writes at addr 254,255,0 (data 0xAA,0xBB,0xCC); msg_end -> frame A5,03,AA,BB,CC (wrap-around read).
REQ-033 300 consecutive writes then msg_end -> LEN byte 0xFF, overflow=1, 255 data bytes starting at first write address.
REQ-034 During busy, pulse wr_en and msg_end -> RAM and frame unchanged, overflow=1, no second frame starts.
REQ-035 msg_end with no prior writes -> uart_tx stays high, busy stays 0.
REQ-036 rst asserted during DATA byte -> uart_tx=1 and busy=0 within same cycle; a new 1-byte message afterwards produces a correct frame A5,01,xx.

Source files
------------

// File: rtl/exi_dump.sv
// EXI capture buffer: stores MOSI bytes in a 256-byte ring and, at end of
// message, dumps SYNC_BYTE, length and payload over an 8N1 UART.
module exi_dump #(
   parameter int unsigned CLK_DIV   = 104,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       msg_end,
   output logic       uart_tx,
   output logic       busy,
   output logic       overflow
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SYNC      = 3'd1,
      ST_LEN       = 3'd2,
      ST_DATA      = 3'd3,
      ST_STOP_WAIT = 3'd4
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 32'd1);

   logic [7:0]  mem_r [0:255];
   logic [7:0]  rd_data_r;
   state_t      state_r;
   logic [15:0] baud_cnt_r;
   logic [3:0]  bit_idx_r;
   logic [7:0]  tx_byte_r;
   logic [7:0]  count_r;
   logic [7:0]  msg_start_r;
   logic [7:0]  data_idx_r;
   logic        uart_tx_r;
   logic        busy_r;
   logic        overflow_r;

   logic        wr_accept_s;
   logic        start_s;
   logic        baud_tick_s;
   logic        next_bit_s;
   logic [7:0]  rd_addr_s;

   // Decode write acceptance, frame start, bit timing and the next serial bit.
   always_comb begin
      wr_accept_s = 1'b0;
      start_s     = 1'b0;
      baud_tick_s = 1'b0;
      next_bit_s  = 1'b1;
      rd_addr_s   = 8'd0;
      if (wr_en && !busy_r) begin
         wr_accept_s = 1'b1;
      end else begin
         wr_accept_s = 1'b0;
      end
      // A byte written alongside msg_end counts toward the frame.
      if (msg_end && !busy_r && ((count_r != 8'd0) || wr_accept_s)) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
      if (baud_cnt_r == BAUD_LAST) begin
         baud_tick_s = 1'b1;
      end else begin
         baud_tick_s = 1'b0;
      end
      if (bit_idx_r < 4'd8) begin
         next_bit_s = tx_byte_r[bit_idx_r[2:0]];
      end else begin
         next_bit_s = 1'b1;
      end
      rd_addr_s = msg_start_r + data_idx_r;
   end

   // Capture RAM with a registered read port that prefetches the next payload byte.
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_r[wr_addr] <= wr_data;
      end
      rd_data_r <= mem_r[rd_addr_s];
   end

   // Capture bookkeeping, error flag and the dump/serialiser state machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         baud_cnt_r  <= 16'd0;
         bit_idx_r   <= 4'd0;
         tx_byte_r   <= 8'd0;
         count_r     <= 8'd0;
         msg_start_r <= 8'd0;
         data_idx_r  <= 8'd0;
         uart_tx_r   <= 1'b1;
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         if (wr_en && busy_r) begin
            overflow_r <= 1'b1;
         end else if (wr_accept_s && (count_r == 8'd255)) begin
            overflow_r <= 1'b1;
         end

         if (wr_accept_s) begin
            if (count_r == 8'd0) begin
               msg_start_r <= wr_addr;
               count_r     <= 8'd1;
            end else if (count_r != 8'd255) begin
               count_r <= count_r + 8'd1;
            end
         end

         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r    <= ST_SYNC;
                  tx_byte_r  <= SYNC_BYTE;
                  bit_idx_r  <= 4'd0;
                  baud_cnt_r <= 16'd0;
                  data_idx_r <= 8'd0;
                  uart_tx_r  <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            ST_SYNC, ST_LEN, ST_DATA, ST_STOP_WAIT: begin
               if (!baud_tick_s) begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end else begin
                  baud_cnt_r <= 16'd0;
                  if (bit_idx_r != 4'd9) begin
                     bit_idx_r <= bit_idx_r + 4'd1;
                     uart_tx_r <= next_bit_s;
                     // data_idx already points past the byte on the wire.
                     if ((bit_idx_r == 4'd8) && (state_r == ST_DATA) && (data_idx_r == count_r)) begin
                        state_r <= ST_STOP_WAIT;
                     end
                  end else begin
                     bit_idx_r <= 4'd0;
                     case (state_r)
                        ST_SYNC: begin
                           state_r   <= ST_LEN;
                           tx_byte_r <= count_r;
                           uart_tx_r <= 1'b0;
                        end
                        ST_LEN, ST_DATA: begin
                           state_r    <= ST_DATA;
                           tx_byte_r  <= rd_data_r;
                           data_idx_r <= data_idx_r + 8'd1;
                           uart_tx_r  <= 1'b0;
                        end
                        ST_STOP_WAIT: begin
                           state_r    <= ST_IDLE;
                           count_r    <= 8'd0;
                           data_idx_r <= 8'd0;
                           uart_tx_r  <= 1'b1;
                           busy_r     <= 1'b0;
                        end
                        default: begin
                           state_r   <= ST_IDLE;
                           uart_tx_r <= 1'b1;
                           busy_r    <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               uart_tx_r <= 1'b1;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign uart_tx  = uart_tx_r;
   assign busy     = busy_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_exi_dump.sv
// Bench for exi_dump: directed captures, UART/busy monitors check against
// expected-byte and expected-busy-length scoreboards.
module tb_exi_dump;

   localparam int CLK_DIV  = 4;
   localparam int HALF     = CLK_DIV / 2;
   localparam int BYTE_CYC = 10 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       msg_end;
   logic       uart_tx;
   logic       busy;
   logic       overflow;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   int         len_q[$];
   logic [7:0] model [256];

   logic       rx_act = 1'b0;
   int         rx_k = 0;
   int         rx_j = 0;
   logic [7:0] rx_byte = 8'd0;
   int         busy_len = 0;
   logic       quiet;

   exi_dump #(.CLK_DIV(CLK_DIV), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .msg_end  (msg_end),
      .uart_tx  (uart_tx),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic exp_frame(input logic [7:0] len);
      exp_q.push_back(8'hA5);
      exp_q.push_back(len);
      len_q.push_back((int'(len) + 2) * BYTE_CYC);
   endtask

   task automatic end_msg(input logic with_wr, input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      msg_end = 1'b1; wr_en = with_wr; wr_addr = a; wr_data = d;
      @(negedge clk);
      msg_end = 1'b0; wr_en = 1'b0;
      chk("busy_rise", busy, 1);
      chk("start_bit_latency", uart_tx, 0);
   endtask

   task automatic wait_done(input int budget);
      int  n    = 0;
      logic seen = 1'b0;
      while ((n < budget) && !(seen && (busy === 1'b0))) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1'b1;
         n++;
      end
      chk("frame_done_in_budget", {31'd0, seen && (busy === 1'b0)}, 1);
   endtask

   task automatic check_quiet(input string name, input int cycles);
      quiet = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if ((busy !== 1'b0) || (uart_tx !== 1'b1)) quiet = 1'b0;
      end
      chk(name, quiet, 1);
   endtask

   // UART receiver: decodes 8N1 from uart_tx, compares against the byte scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            rx_act = 1'b0;
         end else if (!rx_act) begin
            if (uart_tx === 1'b0) begin
               rx_act = 1'b1;
               rx_k   = 0;
            end
         end else begin
            rx_k++;
            if ((rx_k >= HALF) && (((rx_k - HALF) % CLK_DIV) == 0)) begin
               rx_j = (rx_k - HALF) / CLK_DIV;
               if (rx_j == 0) begin
                  chk("rx_start_bit", uart_tx, 0);
               end else if (rx_j <= 8) begin
                  rx_byte[rx_j-1] = uart_tx;
               end else begin
                  chk("rx_stop_bit", uart_tx, 1);
                  if (exp_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL rx_byte: got %0h expected none at %0t", rx_byte, $time);
                  end else begin
                     chk("rx_byte", rx_byte, exp_q.pop_front());
                  end
                  rx_act = 1'b0;
               end
            end
         end
      end
   end

   // Busy monitor: measures each busy period against the expected frame length.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            busy_len = 0;
         end else if (busy === 1'b1) begin
            busy_len++;
         end else if (busy_len > 0) begin
            if (len_q.size() == 0) begin
               total++; bad++;
               $display("FAIL busy_len: got %0d expected none", busy_len);
            end else begin
               chk("busy_len", busy_len, len_q.pop_front());
            end
            busy_len = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; msg_end = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
      #1;
      chk("reset_uart_tx", uart_tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_overflow", overflow, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // basic three-byte message
      wr(8'd0, 8'h11); wr(8'd1, 8'h22); wr(8'd2, 8'h33);
      exp_frame(8'd3);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      end_msg(1'b0, 8'd0, 8'd0);
      wait_done(400);
      chk("overflow_after_basic", overflow, 0);

      // byte written in the same cycle as msg_end is included
      wr(8'd10, 8'h44);
      exp_frame(8'd2);
      exp_q.push_back(8'h44); exp_q.push_back(8'h55);
      end_msg(1'b1, 8'd11, 8'h55);
      wait_done(400);

      // wrap-around read
      wr(8'd254, 8'hAA); wr(8'd255, 8'hBB); wr(8'd0, 8'hCC);
      exp_frame(8'd3);
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
      end_msg(1'b0, 8'd0, 8'd0);
      wait_done(400);
      chk("overflow_after_wrap", overflow, 0);

      // msg_end without any captured bytes
      @(negedge clk); msg_end = 1'b1;
      @(negedge clk); msg_end = 1'b0;
      check_quiet("empty_msg_quiet", 20);

      // write and msg_end while busy are dropped
      wr(8'd19, 8'h77); wr(8'd20, 8'h5A);
      exp_frame(8'd2);
      exp_q.push_back(8'h77); exp_q.push_back(8'h5A);
      end_msg(1'b0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      wr(8'd20, 8'hFF);
      @(negedge clk); msg_end = 1'b1;
      @(negedge clk); msg_end = 1'b0;
      wait_done(400);
      chk("overflow_busy_write", overflow, 1);
      check_quiet("no_second_frame", 60);

      @(negedge clk); rst = 1'b1;
      #1;
      chk("reset_clears_overflow", overflow, 0);
      @(negedge clk); rst = 1'b0;

      // 300 writes saturate count at 255
      for (int i = 0; i < 300; i++) begin
         logic [7:0] a;
         logic [7:0] d;
         a = 8'(100 + i);
         d = 8'(i) ^ 8'h3C;
         model[a] = d;
         wr(a, d);
         if (i == 254) chk("overflow_at_255", overflow, 0);
      end
      chk("overflow_saturate", overflow, 1);
      exp_frame(8'hFF);
      for (int j = 0; j < 255; j++) exp_q.push_back(model[(100 + j) % 256]);
      end_msg(1'b0, 8'd0, 8'd0);
      wait_done(257 * BYTE_CYC + 100);

      // reset during the first payload byte
      wr(8'd50, 8'h01); wr(8'd51, 8'h02); wr(8'd52, 8'h03);
      exp_frame(8'd3);
      exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      end_msg(1'b0, 8'd0, 8'd0);
      repeat (95) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_uart_tx", uart_tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_overflow", overflow, 0);
      @(negedge clk);
      exp_q.delete();
      len_q.delete();
      @(negedge clk);
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 8'd7; wr_data = 8'h9C;
      @(negedge clk);
      wr_en = 1'b0;
      exp_frame(8'd1);
      exp_q.push_back(8'h9C);
      end_msg(1'b0, 8'd0, 8'd0);
      wait_done(200);

      repeat (20) @(negedge clk);
      chk("bytes_left", exp_q.size(), 0);
      chk("frames_left", len_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
